apb_master: RTL
===============

# apb_master

APB initiator that converts single-beat command requests into APB SETUP/ACCESS transfers toward a slave such as the APB memory block. It accepts one command at a time over a valid/ready handshake, drives the APB bus, waits on `pready` with a bounded timeout, and returns read data plus an error flag as a one-cycle response pulse. It sits between a test sequencer or CPU-side agent and the APB slave.

## Interface
- `ADDR_WIDTH`, 7: APB address width.
- `DATA_WIDTH`, 32: APB data width.
- `TIMEOUT`, 16: maximum consecutive ACCESS cycles with `pready` low before the transfer is aborted; legal range 1–255.

- `clk`  in  1  single clock; all logic on rising edge.
- `res`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  master can accept a command.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  target address.
- `cmd_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `paddr`  out  ADDR_WIDTH  APB address.
- `pwdata`  out  DATA_WIDTH  APB write data.
- `prdata`  in  DATA_WIDTH  APB read data.
- `pready`  in  1  slave ready.
- `pslverr`  in  1  slave error.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- `rsp_err`  out  1  `pslverr` sampled at completion, or 1 on timeout.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: `cmd_ready`=1. Handshake `cmd_valid && cmd_ready` latches `cmd_write`, `cmd_addr`, and `cmd_wdata` (forced to 0 for reads) into `pwrite`, `paddr`, and `pwdata`. The FSM then moves to SETUP and `cmd_ready` drops to 0.
- SETUP: `psel`=1, `penable`=0. Always moves to ACCESS after 1 cycle.
- ACCESS: `psel`=1, `penable`=1. The wait counter is cleared on entry.
  - `pready`=1 at a clock edge: transfer completes. Capture `rsp_err`=`pslverr`. Capture `rsp_rdata`=`prdata` if read, else 0. Assert `rsp_valid` for 1 cycle. Go to IDLE.
  - `pready`=0: the wait counter increments. When the counter reaches `TIMEOUT` (i.e., `pready` has been low for `TIMEOUT` consecutive ACCESS cycles), abort with `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0, and go to IDLE.
- `paddr`, `pwrite`, and `pwdata` are stable from SETUP through the end of ACCESS. They hold their last values in IDLE until the next command is accepted.
- `psel` and `penable` are 0 in IDLE.
- The response has no backpressure: `rsp_valid` is a single-cycle pulse and the consumer must take it.
- Wait counter is 8 bits and saturates; it never wraps.

## Timing
- Reset, applied while `res`=0 at a clock edge: state=IDLE, `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `cmd_ready`=0. `cmd_ready` is registered and goes to 1 on the first edge with `res`=1.
- Zero-wait transfer, with the handshake at edge E0:
  - E0→E1 cycle: SETUP.
  - E1→E2 cycle: ACCESS, with `pready` sampled at E2.
  - E2→E3 cycle: `rsp_valid`=1 and `cmd_ready`=1.
- A new command can be accepted at E3. Minimum spacing is 3 cycles per transfer.
- Each wait cycle adds 1 cycle of latency. A timeout gives `rsp_valid` `TIMEOUT`+2 cycles after the handshake.
- `cmd_valid` asserted while `cmd_ready`=0 is ignored. The command must be held until accepted.
- `pready` and `pslverr` are ignored outside ACCESS.
- Reset mid-transfer (SETUP or ACCESS): on the next edge `psel` and `penable` go to 0, no `rsp_valid` is produced, and the command is dropped.
- `pready`=1 on the same edge the timeout counter would expire: the normal completion wins, with `rsp_err`=`pslverr`.

## Test plan
- Reset: hold `res`=0 for 3 cycles, then release. All outputs are 0 during reset, and `cmd_ready` rises 1 cycle after release.
- Write, zero wait: `cmd_addr`=0x05, `cmd_wdata`=0xDEADBEEF, `cmd_write`=1, `pready` tied to 1. Expect SETUP then ACCESS with `paddr`=0x05 and `pwdata`=0xDEADBEEF, then `rsp_valid` with `rsp_err`=0 and `rsp_rdata`=0.
- Read with 3 wait states: `cmd_addr`=0x05, `pready` low for 3 ACCESS cycles, `prdata`=0xDEADBEEF. Expect `penable` high for 4 cycles, `rsp_rdata`=0xDEADBEEF, and `rsp_valid` 6 cycles after the handshake.
- Slave error: read 0x3F with `pready`=1 and `pslverr`=1. Expect `rsp_err`=1 and `rsp_rdata`=`prdata`.
- Timeout: `TIMEOUT`=16, `pready` held at 0. Expect exactly 16 ACCESS cycles, then `rsp_valid`, `rsp_err`=1, `rsp_rdata`=0, and `psel`=0.
- Reset mid-ACCESS, then back-to-back commands: drive `res`=0 during a waited ACCESS and expect `psel`=0 next cycle with no `rsp_valid`. After recovery, issue 4 consecutive writes with `cmd_valid` held high and expect handshakes exactly 3 cycles apart.

Source files
------------

// File: rtl/apb_master.sv
// APB initiator: single-beat commands in, SETUP/ACCESS transfers out,
// one-cycle response pulse with read data, slave error or timeout.
module apb_master #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  // last wait count that may still see pready; one more low sample aborts
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_d;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       done;
  logic       abort;

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (wait_cnt >= WAIT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cmd_ready <= (state_d == IDLE);
      psel      <= (state_d != IDLE);
      penable   <= (state_d == ACCESS);
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_write ? cmd_wdata : '0;
      end
      if (state != ACCESS) begin
        wait_cnt <= '0;
      end else if (!pready && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      rsp_valid <= done || abort;
      rsp_rdata <= (done && !pwrite) ? prdata : '0;
      rsp_err   <= done ? pslverr : abort;
    end
  end

endmodule
